pe_vec_gf: RTL and testbench

- Parametrised successor of the 8-bit AES processing element for the FeRAM near-memory systolic array.
- Holds a LANES-byte partial-sum vector and executes one command at a time through a valid/ready command port.
- Commands cover AddRoundKey XOR, forward/inverse MixColumns per 4-lane column, load, intra-column byte rotate, clear, and a multi-cycle GF(2^8) multiply.
- Results are exposed on psum_out with a one-cycle res_valid strobe.

---
 rtl/pe_vec_gf.sv | 211 +++++++++++++++++++++
 tb/tb_pe_vec_gf.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_vec_gf.sv
// pe_vec_gf: LANES-byte GF(2^8) processing element for the near-memory systolic array.
// Holds a partial-sum byte vector and executes one command at a time through a
// valid/ready port: XOR, (Inv)MixColumns per 4-lane column, load, column rotate,
// clear and, when the macro PE_GFMUL_EN is defined, a multi-cycle GF(2^8) multiply.
// Without PE_GFMUL_EN opcode 4 behaves as an illegal opcode and busy stays low.
module pe_vec_gf #(
    parameter int LANES = 4,
    parameter int ID_X  = 0,
    parameter int ID_Y  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pe_en,
    input  logic               flush,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic               cmd_dec,
    input  logic [LANES*8-1:0] cmd_data,
    output logic [LANES*8-1:0] psum_out,
    output logic               res_valid,
    output logic               busy,
    output logic               err
);
    localparam int W    = LANES * 8;
    localparam int COLS = LANES / 4;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_MIXCOL = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_GFMUL  = 3'd4;
    localparam logic [2:0] OP_ROT    = 3'd5;
    localparam logic [2:0] OP_CLEAR  = 3'd6;
    localparam logic [2:0] OP_ILL    = 3'd7;

    // Tile position parameters only need to be sane; the lane count must form whole columns.
    if ((LANES < 4) || (LANES % 4 != 0) || (ID_X < 0) || (ID_Y < 0)) begin : g_param_check
        $error("pe_vec_gf: LANES must be a positive multiple of 4 and IDs non-negative");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by a small constant (<16) built from repeated xtime.
    function automatic logic [7:0] gf_mul_c(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic dec);
        logic [7:0] a0, a1, a2, a3, r0, r1, r2, r3;
        {a3, a2, a1, a0} = col;
        if (!dec) begin
            r0 = xtime(a0) ^ gf_mul_c(a1, 4'd3) ^ a2 ^ a3;
            r1 = a0 ^ xtime(a1) ^ gf_mul_c(a2, 4'd3) ^ a3;
            r2 = a0 ^ a1 ^ xtime(a2) ^ gf_mul_c(a3, 4'd3);
            r3 = gf_mul_c(a0, 4'd3) ^ a1 ^ a2 ^ xtime(a3);
        end else begin
            r0 = gf_mul_c(a0, 4'd14) ^ gf_mul_c(a1, 4'd11) ^ gf_mul_c(a2, 4'd13) ^ gf_mul_c(a3, 4'd9);
            r1 = gf_mul_c(a0, 4'd9) ^ gf_mul_c(a1, 4'd14) ^ gf_mul_c(a2, 4'd11) ^ gf_mul_c(a3, 4'd13);
            r2 = gf_mul_c(a0, 4'd13) ^ gf_mul_c(a1, 4'd9) ^ gf_mul_c(a2, 4'd14) ^ gf_mul_c(a3, 4'd11);
            r3 = gf_mul_c(a0, 4'd11) ^ gf_mul_c(a1, 4'd13) ^ gf_mul_c(a2, 4'd9) ^ gf_mul_c(a3, 4'd14);
        end
        return {r3, r2, r1, r0};
    endfunction

    // New row r takes old row (r+n)%4: a byte-granular rotate of the doubled column.
    function automatic logic [31:0] rot_col(input logic [31:0] col, input logic [1:0] n);
        logic [63:0] dbl;
        dbl = {col, col};
        return dbl[int'(n) * 8 +: 32];
    endfunction

    logic [W-1:0] psum_q;
    logic [W-1:0] op_psum;
    logic         res_valid_q;
    logic         err_q;
    logic         op_err;
    logic         idle;
    logic         accept;
    logic         op_single;

    assign cmd_ready = rst_n & pe_en & ~flush & idle;
    assign accept    = cmd_valid & cmd_ready;

    // Result of the single-cycle opcodes applied to the current psum.
    always_comb begin
        op_psum = psum_q;
        op_err  = 1'b0;
        case (cmd_op)
            OP_NOP:    op_psum = psum_q;
            OP_XOR:    op_psum = psum_q ^ cmd_data;
            OP_MIXCOL: for (int c = 0; c < COLS; c++) op_psum[32*c +: 32] = mix_col(psum_q[32*c +: 32], cmd_dec);
            OP_LOAD:   op_psum = cmd_data;
            OP_ROT:    for (int c = 0; c < COLS; c++) op_psum[32*c +: 32] = rot_col(psum_q[32*c +: 32], cmd_data[1:0]);
            OP_CLEAR:  op_psum = '0;
`ifndef PE_GFMUL_EN
            OP_GFMUL:  op_err = 1'b1;
`endif
            OP_ILL:    op_err = 1'b1;
            default:   op_psum = psum_q;
        endcase
    end

`ifdef PE_GFMUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [W-1:0] mul_a_q, mul_b_q, acc_q, acc_step;
    logic         mul_start, mul_done;

    assign idle      = (state_q == S_IDLE);
    assign busy      = (state_q == S_MUL);
    assign op_single = (cmd_op != OP_GFMUL);
    assign mul_start = accept & (cmd_op == OP_GFMUL);
    assign mul_done  = pe_en & ~flush & (state_q == S_MUL) & (cnt_q == 3'd0);

    // One MSB-first shift-and-add step per lane, reduced by x^8+x^4+x^3+x+1.
    always_comb begin
        acc_step = '0;
        for (int l = 0; l < LANES; l++)
            acc_step[8*l +: 8] = xtime(acc_q[8*l +: 8]) ^ (mul_b_q[8*l + int'(cnt_q)] ? mul_a_q[8*l +: 8] : 8'h00);
    end

    // Multiply control state and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: start on an accepted GFMUL, leave after the eighth step or on flush.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pe_en) begin
            if (flush) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (mul_start) begin
                        state_d = S_MUL;
                        cnt_d   = 3'd7;
                    end
                    S_MUL: begin
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Operand and accumulator registers; pure data, so no reset.
    always_ff @(posedge clk) begin
        if (pe_en && !flush) begin
            if (mul_start) begin
                mul_a_q <= psum_q;
                mul_b_q <= cmd_data;
                acc_q   <= '0;
            end else if (state_q == S_MUL) begin
                acc_q <= acc_step;
            end
        end
    end
`else
    assign idle      = 1'b1;
    assign busy      = 1'b0;
    assign op_single = 1'b1;
`endif

    // Partial sum, sticky error and completion strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_q      <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (!pe_en) begin
            res_valid_q <= 1'b0;
        end else if (flush) begin
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (accept && op_single) begin
            psum_q      <= op_psum;
            res_valid_q <= 1'b1;
            if (op_err) err_q <= 1'b1;
`ifdef PE_GFMUL_EN
        end else if (mul_done) begin
            psum_q      <= acc_step;
            res_valid_q <= 1'b1;
`endif
        end else begin
            res_valid_q <= 1'b0;
        end
    end

    assign psum_out  = psum_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
endmodule

// File: tb/tb_pe_vec_gf.sv
`timescale 1ns/1ps
module tb_pe_vec_gf;
    localparam int LANES = 8;
    localparam int W     = LANES * 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pe_en = 1'b0;
    logic         flush = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_dec = 1'b0;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_ready, res_valid, busy, err;
    logic [W-1:0] psum_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    pe_vec_gf #(.LANES(LANES), .ID_X(1), .ID_Y(2)) dut (
        .clk(clk), .rst_n(rst_n), .pe_en(pe_en), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dec(cmd_dec), .cmd_data(cmd_data), .psum_out(psum_out),
        .res_valid(res_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] mc_coef(input logic inv, input int k);
        logic [7:0] fwd_t [4];
        logic [7:0] inv_t [4];
        fwd_t = '{8'h02, 8'h03, 8'h01, 8'h01};
        inv_t = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        return inv ? inv_t[k] : fwd_t[k];
    endfunction

    logic [7:0] m_psum [LANES];
    logic [7:0] m_res  [LANES];
    int         m_left;
    bit         m_rv, m_err;

    // Model advances on the same edges as the DUT; inputs are stable there.
    always @(posedge clk or negedge rst_n) begin
        logic [7:0] old [LANES];
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) m_psum[i] = 8'h00;
            m_left = 0; m_rv = 0; m_err = 0;
        end else if (!pe_en) begin
            m_rv = 0;
        end else if (flush) begin
            m_left = 0; m_rv = 0; m_err = 0;
        end else if (m_left > 0) begin
            m_rv = 0;
            m_left--;
            if (m_left == 0) begin
                m_psum = m_res;
                m_rv = 1;
            end
        end else if (cmd_valid) begin
            old = m_psum;
            m_rv = 1;
            case (cmd_op)
                3'd1: for (int i = 0; i < LANES; i++) m_psum[i] = old[i] ^ cmd_data[8*i +: 8];
                3'd2: for (int i = 0; i < LANES; i++) begin
                    m_psum[i] = 8'h00;
                    for (int c = 0; c < 4; c++)
                        m_psum[i] ^= gmul(mc_coef(cmd_dec, (c - i % 4 + 4) % 4), old[(i / 4) * 4 + c]);
                end
                3'd3: for (int i = 0; i < LANES; i++) m_psum[i] = cmd_data[8*i +: 8];
                3'd4: begin
`ifdef PE_GFMUL_EN
                    for (int i = 0; i < LANES; i++) m_res[i] = gmul(old[i], cmd_data[8*i +: 8]);
                    m_left = 8;
                    m_rv = 0;
`else
                    m_err = 1;
`endif
                end
                3'd5: for (int i = 0; i < LANES; i++)
                    m_psum[i] = old[(i / 4) * 4 + (i % 4 + int'(cmd_data[1:0])) % 4];
                3'd6: for (int i = 0; i < LANES; i++) m_psum[i] = 8'h00;
                3'd7: m_err = 1;
                default: ;
            endcase
        end else begin
            m_rv = 0;
        end
    end

    logic [W-1:0] cmp_exp;

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < LANES; i++) cmp_exp[8*i +: 8] = m_psum[i];
            chk("cmp_psum", psum_out, cmp_exp);
            chkb("cmp_res_valid", res_valid, m_rv);
            chkb("cmp_err", err, m_err);
            chkb("cmp_busy", busy, m_left > 0);
            chkb("cmp_cmd_ready", cmd_ready, rst_n & pe_en & ~flush & (m_left == 0));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input logic [2:0] op, input logic dec, input logic [W-1:0] data,
                         input int stall_at, input int stall_len, input int flush_at,
                         output int lat, output int low);
        int n;
        @(posedge clk); #1;
        cmd_op = op; cmd_dec = dec; cmd_data = data; cmd_valid = 1'b1; pe_en = 1'b1; flush = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin n++; @(negedge clk); end
        chkb("accept_wait", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = -1; low = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            pe_en = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            flush = (cyc == flush_at);
            @(negedge clk);
            if (res_valid) begin lat = cyc; break; end
            if (!cmd_ready) low++;
            @(posedge clk); #1;
        end
        if (lat < 0) begin pe_en = 1'b1; flush = 1'b0; end
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush = 1'b1; pe_en = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
    endtask

    localparam logic [2:0] NOP = 3'd0, XOR = 3'd1, MIX = 3'd2, LOAD = 3'd3,
                           GFMUL = 3'd4, ROT = 3'd5, ILL = 3'd7;
    localparam logic [W-1:0] COLV = 64'h5c220af2_455313db;

    initial begin
        int lat, low, n, rv_cnt;
        chk_en = 1'b1;
        pe_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_psum", psum_out, '0);
        chkb("rst_ready", cmd_ready, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_err", err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(LOAD, 1'b0, {LANES{8'h32}}, 0, 0, 0, lat, low);
        chki("load_latency", lat, 1);
        issue(XOR, 1'b0, {LANES{8'h2B}}, 0, 0, 0, lat, low);
        chki("xor_latency", lat, 1);
        chk("xor_psum", psum_out, {LANES{8'h19}});
        chkb("xor_err", err, 1'b0);

        issue(LOAD, 1'b0, COLV, 0, 0, 0, lat, low);
        issue(MIX, 1'b0, '0, 0, 0, 0, lat, low);
        chk("mixcol_fwd", psum_out, 64'h9d58dc9f_bca14d8e);
        issue(MIX, 1'b1, '0, 0, 0, 0, lat, low);
        chk("mixcol_inv", psum_out, COLV);

        issue(LOAD, 1'b0, {LANES{8'h57}}, 0, 0, 0, lat, low);
        issue(GFMUL, 1'b0, {LANES{8'h83}}, 0, 0, 0, lat, low);
`ifdef PE_GFMUL_EN
        chki("gfmul_latency", lat, 9);
        chki("gfmul_ready_low", low, 8);
        chk("gfmul_psum", psum_out, {LANES{8'hC1}});

        issue(LOAD, 1'b0, {LANES{8'h57}}, 0, 0, 0, lat, low);
        issue(GFMUL, 1'b0, {LANES{8'h83}}, 3, 3, 0, lat, low);
        chki("gfmul_stall_latency", lat, 12);
        chk("gfmul_stall_psum", psum_out, {LANES{8'hC1}});

        issue(LOAD, 1'b0, {LANES{8'h57}}, 0, 0, 0, lat, low);
        issue(GFMUL, 1'b0, {LANES{8'h83}}, 0, 0, 4, lat, low);
        chki("gfmul_flush_no_result", lat, -1);
        @(negedge clk);
        chkb("gfmul_flush_busy", busy, 1'b0);
        chk("gfmul_flush_psum", psum_out, {LANES{8'h57}});

        // Next command held valid across the multiply.
        @(posedge clk); #1;
        cmd_op = GFMUL; cmd_data = {LANES{8'h83}}; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        cmd_op = LOAD; cmd_data = {LANES{8'hAA}};
        lat = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (res_valid) begin lat = cyc; break; end
            @(posedge clk); #1;
        end
        chki("held_gfmul_latency", lat, 9);
        chk("held_gfmul_psum", psum_out, {LANES{8'hC1}});
        chkb("held_ready_after", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chkb("held_load_rv", res_valid, 1'b1);
        chk("held_load_psum", psum_out, {LANES{8'hAA}});

        // Asynchronous reset in the middle of a multiply.
        @(posedge clk); #1;
        cmd_op = GFMUL; cmd_data = {LANES{8'h83}}; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chkb("arst_busy", busy, 1'b0);
        chk("arst_psum", psum_out, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rv_cnt = 0;
        repeat (12) begin @(negedge clk); if (res_valid) rv_cnt++; end
        chki("arst_no_completion", rv_cnt, 0);
`else
        chki("gfmul_illegal_latency", lat, 1);
        chkb("gfmul_illegal_err", err, 1'b1);
        chk("gfmul_illegal_psum", psum_out, {LANES{8'h57}});
        chkb("gfmul_illegal_busy", busy, 1'b0);
        pulse_flush();
        chkb("gfmul_illegal_flush_err", err, 1'b0);
`endif

        issue(LOAD, 1'b0, 64'h08070605_04030201, 0, 0, 0, lat, low);
        issue(ROT, 1'b0, 64'h1, 0, 0, 0, lat, low);
        chk("rot1_psum", psum_out, 64'h05080706_01040302);
        issue(ILL, 1'b0, '1, 0, 0, 0, lat, low);
        chkb("illegal_err", err, 1'b1);
        chk("illegal_psum", psum_out, 64'h05080706_01040302);
        pulse_flush();
        chkb("flush_clears_err", err, 1'b0);
        chk("flush_keeps_psum", psum_out, 64'h05080706_01040302);

        // Randomized traffic checked cycle by cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            rst_n     = ($urandom_range(0, 399) != 0);
            pe_en     = ($urandom_range(0, 99) < 85);
            flush     = ($urandom_range(0, 99) < 3);
            cmd_valid = ($urandom_range(0, 99) < 60);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_dec   = 1'($urandom_range(0, 1));
            cmd_data  = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        rst_n = 1'b1; cmd_valid = 1'b0; flush = 1'b0; pe_en = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
